// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide unit (XLEN+2 cycle latency).
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiplies and divide-by-zero finish one cycle after start.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [XLEN-1:0]   hi_q, hi_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2:0]        op_q, op_d;
  logic              neg_a_q, neg_a_d;
  logic              neg_b_q, neg_b_d;
  logic              bz_q, bz_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic              a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, fix_res;
  logic              early;
  logic [XLEN-1:0]   early_res;

  // MUL needs no sign handling: the low half is identical for signed and unsigned operands.
  assign a_signed = (funct3 == 3'b001) || (funct3 == 3'b010) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign b_signed = (funct3 == 3'b001) || (funct3 == 3'b100) || (funct3 == 3'b110);
  assign a_neg    = a_signed & a[XLEN-1];
  assign b_neg    = b_signed & b[XLEN-1];
  assign a_mag    = a_neg ? -a : a;
  assign b_mag    = b_neg ? -b : b;

`ifdef MULDIV_EARLY_OUT_EN
  assign early     = funct3[2] ? (b == '0) : ((a == '0) || (b == '0));
  assign early_res = funct3[2] ? (funct3[1] ? a : '1) : '0;
`else
  assign early     = 1'b0;
  assign early_res = '0;
`endif

  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_q, lo_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ok    = ~div_diff[XLEN];

  assign prod     = {hi_q, lo_q};
  assign prod_fix = (neg_a_q ^ neg_b_q) ? -prod : prod;
  assign quo_fix  = (neg_a_q ^ neg_b_q) ? -lo_q : lo_q;
  assign rem_fix  = neg_a_q ? -hi_q : hi_q;

  always_comb begin
    fix_res = '0;
    case (op_q)
      3'b000:         fix_res = prod_fix[XLEN-1:0];
      3'b001, 3'b010,
      3'b011:         fix_res = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101: fix_res = bz_q ? '1 : quo_fix;
      default:        fix_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    op_d     = op_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    bz_d     = bz_q;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = funct3;
          neg_a_d = a_neg;
          neg_b_d = b_neg;
          bz_d    = (b == '0);
          hi_d    = '0;
          lo_d    = funct3[2] ? a_mag : b_mag;
          opnd_d  = funct3[2] ? b_mag : a_mag;
          if (early) begin
            cnt_d    = '0;
            result_d = early_res;
            state_d  = S_DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN);
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (kill) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
          // Divide: hi holds the partial remainder, lo shifts the dividend out and quotient bits in.
          if (op_q[2]) begin
            hi_d = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], div_ok};
          end else begin
            {hi_d, lo_d} = {mul_sum, lo_q[XLEN-1:1]};
          end
          if (cnt_q == CNT_W'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (kill) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          result_d = fix_res;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      op_q     <= '0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      bz_q     <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      op_q     <= op_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      bz_q     <= bz_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;

endmodule
